// File: rtl/kp_pkg.sv
// Shared constants and types for the keypad scanner / dot-matrix controller.
package kp_pkg;
  localparam int KP_N_DEF   = 4;
  localparam int DOT_N_DEF  = 2 * KP_N_DEF;
  localparam int CODE_W_DEF = $clog2(KP_N_DEF * KP_N_DEF);

  localparam int MODE_LAST   = 0;
  localparam int MODE_TOGGLE = 1;

  typedef enum logic [1:0] {IDLE, CAND, HELD} deb_state_e;
endpackage

// File: rtl/keypad_dot_ctrl_tick_gen.sv
// Free-running prescaler: counts 0..DIV-1 and flags the last count as a one-clock tick.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(DIV - 1)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == CW'(DIV - 1));
endmodule

// File: rtl/keypad_dot_ctrl.sv
// Keypad scanner with whole-scan debounce and key events, driving a multiplexed
// dot matrix where every key owns one 2x2 cell; MODE picks last-key or toggle display.
module keypad_dot_ctrl
  import kp_pkg::*;
#(
  parameter int KP_N     = KP_N_DEF,
  parameter int SCAN_DIV = 500000,
  parameter int DOT_DIV  = 5000,
  parameter int DEB_CNT  = 3,
  parameter int MODE     = MODE_LAST,
  localparam int DOT_N   = 2 * KP_N,
  localparam int CODE_W  = $clog2(KP_N * KP_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [KP_N-1:0]   keypadCol,
  input  logic              clr,
  output logic [KP_N-1:0]   keypadRow,
  output logic [DOT_N-1:0]  dot_row,
  output logic [DOT_N-1:0]  dot_col,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code
);
  localparam int NKEYS = KP_N * KP_N;
  localparam int RW    = (KP_N > 1) ? $clog2(KP_N) : 1;
  localparam int KW    = $clog2(DOT_N);
  localparam int DW    = $clog2(DEB_CNT + 1);

  logic scanTick, dotTick;

  tick_gen #(.DIV(SCAN_DIV)) uScanTick (.clk(clk), .rst(rst), .tick(scanTick));
  tick_gen #(.DIV(DOT_DIV))  uDotTick  (.clk(clk), .rst(rst), .tick(dotTick));

  logic [RW-1:0]     rowIdx_q;
  logic [KP_N-1:0]   keypadRow_q;
  logic [1:0]        hits_q;
  logic [CODE_W-1:0] first_q, cand_q, keyCode_q;
  logic [DW-1:0]     cnt_q;
  deb_state_e        state_q;
  logic [NKEYS-1:0]  bitmap_q;
  logic              keyValid_q;
  logic [KW-1:0]     dotIdx_q;
  logic [DOT_N-1:0]  dotRow_q, dotCol_q;

  logic [1:0]        slotHits, scanHits;
  logic [RW-1:0]     slotCol;
  logic [CODE_W-1:0] slotCode, scanFirst, acceptCode;
  logic              endOfScan, acceptNow;
  logic [NKEYS-1:0]  acceptOneHot;

  // The hit count and first code include the slot being sampled right now, so the
  // end-of-scan decision sees all KP_N slots of the scan.
  always_comb begin
    slotHits = 2'd0;
    slotCol  = '0;
    for (int c = 0; c < KP_N; c++) begin
      if (!keypadCol[c]) begin
        if (slotHits == 2'd0) slotCol = RW'(c);
        slotHits = (slotHits == 2'd0) ? 2'd1 : 2'd2;
      end
    end
    slotCode  = CODE_W'(int'(rowIdx_q) * KP_N + int'(slotCol));
    scanHits  = (({1'b0, hits_q} + {1'b0, slotHits}) >= 3'd2) ? 2'd2 : (hits_q + slotHits);
    scanFirst = (hits_q == 2'd0 && slotHits != 2'd0) ? slotCode : first_q;
    endOfScan = scanTick && (rowIdx_q == RW'(KP_N - 1));

    acceptNow  = 1'b0;
    acceptCode = cand_q;
    if (endOfScan && scanHits == 2'd1) begin
      if (state_q == IDLE && DEB_CNT == 1) begin
        acceptNow  = 1'b1;
        acceptCode = scanFirst;
      end else if (state_q == CAND && scanFirst == cand_q && cnt_q == DW'(DEB_CNT - 1)) begin
        acceptNow = 1'b1;
      end
    end
    acceptOneHot = '0;
    acceptOneHot[acceptCode] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rowIdx_q    <= '0;
      keypadRow_q <= {{(KP_N-1){1'b1}}, 1'b0};
      hits_q      <= 2'd0;
      first_q     <= '0;
      cand_q      <= '0;
      cnt_q       <= '0;
      state_q     <= IDLE;
      bitmap_q    <= '0;
      keyValid_q  <= 1'b0;
      keyCode_q   <= '0;
    end else begin
      keyValid_q <= acceptNow;
      if (acceptNow) keyCode_q <= acceptCode;
      if (clr) begin
        bitmap_q <= '0;
      end else if (acceptNow) begin
        bitmap_q <= (MODE == MODE_TOGGLE) ? (bitmap_q ^ acceptOneHot) : acceptOneHot;
      end

      if (scanTick) begin
        rowIdx_q    <= (rowIdx_q == RW'(KP_N - 1)) ? '0 : rowIdx_q + 1'b1;
        keypadRow_q <= {keypadRow_q[KP_N-2:0], keypadRow_q[KP_N-1]};
        hits_q      <= endOfScan ? 2'd0 : scanHits;
        first_q     <= endOfScan ? '0 : scanFirst;
      end

      // HELD only leaves on an empty scan, so a long hold never repeats.
      if (endOfScan) begin
        unique case (state_q)
          IDLE: begin
            if (scanHits == 2'd1) begin
              cand_q  <= scanFirst;
              cnt_q   <= DW'(1);
              state_q <= (DEB_CNT == 1) ? HELD : CAND;
            end
          end
          CAND: begin
            if (scanHits != 2'd1) begin
              state_q <= IDLE;
            end else if (scanFirst != cand_q) begin
              cand_q <= scanFirst;
              cnt_q  <= DW'(1);
            end else if (acceptNow) begin
              state_q <= HELD;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          HELD: begin
            if (scanHits == 2'd0) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  logic [KW-1:0]    dotIdxNext;
  logic [DOT_N-1:0] dotRowNext, dotColNext;

  always_comb begin
    dotIdxNext = (dotIdx_q == KW'(DOT_N - 1)) ? '0 : dotIdx_q + 1'b1;
    dotRowNext = '1;
    dotRowNext[KW'(DOT_N - 1) - dotIdxNext] = 1'b0;
    dotColNext = '0;
    for (int r = 0; r < KP_N; r++) begin
      if (bitmap_q[r * KP_N + int'(dotIdxNext[KW-1:1])]) dotColNext[2*r +: 2] = 2'b11;
    end
  end

  // Row select and column data load together from the bitmap as it stands at the tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dotIdx_q <= '0;
      dotRow_q <= '1;
      dotCol_q <= '0;
    end else if (dotTick) begin
      dotIdx_q <= dotIdxNext;
      dotRow_q <= dotRowNext;
      dotCol_q <= dotColNext;
    end
  end

  assign keypadRow = keypadRow_q;
  assign dot_row   = dotRow_q;
  assign dot_col   = dotCol_q;
  assign key_valid = keyValid_q;
  assign key_code  = keyCode_q;
endmodule

// File: tb/tb_keypad_dot_ctrl.sv
// Bench for keypad_dot_ctrl: one DUT per display mode, a keypad model per DUT,
// and a key-event scoreboard that also tracks the expected cell bitmap.
module tb_keypad_dot_ctrl;
  localparam int KP_N      = 4;
  localparam int SCAN_DIV  = 4;
  localparam int DOT_DIV   = 2;
  localparam int DEB_CNT   = 2;
  localparam int DOT_N     = 2 * KP_N;
  localparam int SCAN_CLKS = SCAN_DIV * KP_N;

  typedef struct packed {
    logic [3:0] code;
    logic       clrHit;
  } keyEvent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] pressMask = '0;
  logic [3:0]  keypadRow0, keypadRow1, keypadCol0, keypadCol1;
  logic [7:0]  dotRow0, dotRow1, dotCol0, dotCol1;
  logic        keyValid0, keyValid1;
  logic [3:0]  keyCode0, keyCode1;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  keyEvent_t   q0[$];
  keyEvent_t   q1[$];
  keyEvent_t   ev0, ev1;
  logic [15:0] bm0 = '0;
  logic [15:0] bm1 = '0;

  always #5 clk = ~clk;

  keypad_dot_ctrl #(.KP_N(KP_N), .SCAN_DIV(SCAN_DIV), .DOT_DIV(DOT_DIV), .DEB_CNT(DEB_CNT), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .keypadCol(keypadCol0), .clr(clr), .keypadRow(keypadRow0),
    .dot_row(dotRow0), .dot_col(dotCol0), .key_valid(keyValid0), .key_code(keyCode0));

  keypad_dot_ctrl #(.KP_N(KP_N), .SCAN_DIV(SCAN_DIV), .DOT_DIV(DOT_DIV), .DEB_CNT(DEB_CNT), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .keypadCol(keypadCol1), .clr(clr), .keypadRow(keypadRow1),
    .dot_row(dotRow1), .dot_col(dotCol1), .key_valid(keyValid1), .key_code(keyCode1));

  // A pressed key pulls its column low while its row is driven low.
  function automatic logic [3:0] colModel(input logic [15:0] mask, input logic [3:0] rows);
    logic [3:0] col;
    col = '1;
    for (int r = 0; r < KP_N; r++)
      for (int c = 0; c < KP_N; c++)
        if (mask[r*KP_N + c] && !rows[r]) col[c] = 1'b0;
    return col;
  endfunction

  function automatic logic [7:0] expDotCol(input logic [15:0] bm, input int k);
    logic [7:0] col;
    col = '0;
    for (int r = 0; r < KP_N; r++)
      if (bm[r*KP_N + k/2]) col[2*r +: 2] = 2'b11;
    return col;
  endfunction

  assign keypadCol0 = colModel(pressMask, keypadRow0);
  assign keypadCol1 = colModel(pressMask, keypadRow1);

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Scoreboard: every key_valid pulse pops one expected event.
  always @(negedge clk) begin
    if (rst && keyValid0) begin
      if (q0.size() == 0) begin
        checkOutput("kv0_unexpected", 32'(keyValid0), 32'd0);
      end else begin
        ev0 = q0.pop_front();
        checkOutput("kcode0", 32'(keyCode0), 32'(ev0.code));
        bm0 = ev0.clrHit ? 16'h0 : (16'h1 << ev0.code);
      end
    end
    if (rst && keyValid1) begin
      if (q1.size() == 0) begin
        checkOutput("kv1_unexpected", 32'(keyValid1), 32'd0);
      end else begin
        ev1 = q1.pop_front();
        checkOutput("kcode1", 32'(keyCode1), 32'(ev1.code));
        bm1 = ev1.clrHit ? 16'h0 : (bm1 ^ (16'h1 << ev1.code));
      end
    end
  end

  task automatic expectKey(input logic [3:0] code, input logic clrHit);
    keyEvent_t ev;
    ev.code   = code;
    ev.clrHit = clrHit;
    q0.push_back(ev);
    q1.push_back(ev);
  endtask

  task automatic alignScan();
    @(negedge clk);
    while (cyc % SCAN_CLKS != 0) @(negedge clk);
  endtask

  // Hold a key set for whole scans, then release and leave two empty scans.
  task automatic applyStimulus(input logic [15:0] mask, input int nScans);
    alignScan();
    pressMask = mask;
    repeat (nScans * SCAN_CLKS) @(negedge clk);
    pressMask = '0;
    repeat (2 * SCAN_CLKS) @(negedge clk);
  endtask

  task automatic checkDisplay(input string tag);
    int t, k;
    logic [7:0] er, ec0, ec1;
    for (int i = 0; i < DOT_N * DOT_DIV; i++) begin
      @(negedge clk);
      t = cyc / DOT_DIV;
      if (t == 0) begin
        er = 8'hFF; ec0 = 8'h00; ec1 = 8'h00;
      end else begin
        k   = t % DOT_N;
        er  = ~(8'b1 << (DOT_N - 1 - k));
        ec0 = expDotCol(bm0, k);
        ec1 = expDotCol(bm1, k);
      end
      checkOutput({tag, "_row0"}, 32'(dotRow0), 32'(er));
      checkOutput({tag, "_col0"}, 32'(dotCol0), 32'(ec0));
      checkOutput({tag, "_row1"}, 32'(dotRow1), 32'(er));
      checkOutput({tag, "_col1"}, 32'(dotCol1), 32'(ec1));
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_krow0"}, 32'(keypadRow0), 32'h0E);
    checkOutput({tag, "_krow1"}, 32'(keypadRow1), 32'h0E);
    checkOutput({tag, "_drow0"}, 32'(dotRow0), 32'hFF);
    checkOutput({tag, "_drow1"}, 32'(dotRow1), 32'hFF);
    checkOutput({tag, "_dcol0"}, 32'(dotCol0), 32'h00);
    checkOutput({tag, "_dcol1"}, 32'(dotCol1), 32'h00);
    checkOutput({tag, "_kv0"}, 32'(keyValid0), 32'd0);
    checkOutput({tag, "_kc0"}, 32'(keyCode0), 32'd0);
    checkOutput({tag, "_kc1"}, 32'(keyCode1), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst = 1'b1;

    // Key (1,2) held three scans: one event, cell 6 lit.
    expectKey(4'd6, 1'b0);
    applyStimulus(16'h0040, 3);
    checkDisplay("t1");

    // One-scan bounce and a two-key chord: neither produces an event.
    applyStimulus(16'h0040, 1);
    checkDisplay("t2");
    applyStimulus(16'h8001, 4);
    checkDisplay("t3");

    // Key (2,1) pressed twice; the second press is a long hold with a single event.
    expectKey(4'd9, 1'b0);
    applyStimulus(16'h0200, 3);
    checkDisplay("t4a");
    expectKey(4'd9, 1'b0);
    applyStimulus(16'h0200, 10);
    checkDisplay("t4b");

    // clr coincides with the accept edge of key 5 (end of its second scan).
    expectKey(4'd5, 1'b1);
    alignScan();
    pressMask = 16'h0020;
    repeat (2 * SCAN_CLKS - 1) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (SCAN_CLKS) @(negedge clk);
    pressMask = '0;
    repeat (2 * SCAN_CLKS) @(negedge clk);
    checkDisplay("t5");

    // Asynchronous reset in mid-slot with a lit bitmap and a non-zero key code.
    expectKey(4'd3, 1'b0);
    applyStimulus(16'h0008, 3);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 checkResetState("midrst");
    bm0 = '0;
    bm1 = '0;
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (keypadRow0 == 4'b1110 && n < 20);
    checkOutput("first_scan_tick", 32'(n), 32'd4);
    checkDisplay("t6");

    checkOutput("q0_pending", 32'(q0.size()), 32'd0);
    checkOutput("q1_pending", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
